inst_queue: RTL

//   Circular FIFO between instruction fetcher and decoder. Buffers fetched {inst, pc} pairs.

---
 rtl/inst_queue_pkg.sv | 9 +
 rtl/inst_queue.sv | 91 +++++++++
 2 files changed

// File: rtl/inst_queue_pkg.sv
// Shared widths and default geometry for the fetch-to-decode instruction queue.
package inst_queue_pkg;

   localparam int INSTRUCTION_WIDTH = 32;
   localparam int ADDRESS_WIDTH     = 32;
   localparam int IQ_DEPTH_LOG2     = 4;
   localparam int IQ_FULL_SLACK     = 1;

endpackage

// File: rtl/inst_queue.sv
// Circular FIFO of {inst, pc} pairs between fetcher and decoder.
// Head entry is presented combinationally and popped when dispatch accepts it; a flush empties the queue.
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int DEPTH_LOG2 = IQ_DEPTH_LOG2,
   parameter int FULL_SLACK = IQ_FULL_SLACK
) (
   input  logic                         clk_in,
   input  logic                         rst_n_in,
   input  logic                         rdy_in,
   input  logic                         rob_flush_in,
   input  logic                         fetcher_en_in,
   input  logic [INSTRUCTION_WIDTH-1:0] fetcher_inst_in,
   input  logic [ADDRESS_WIDTH-1:0]     fetcher_pc_in,
   output logic                         fetcher_full_out,
   input  logic                         dispatcher_stall_in,
   output logic                         decoder_inst_en_out,
   output logic [INSTRUCTION_WIDTH-1:0] decoder_inst_out,
   output logic [ADDRESS_WIDTH-1:0]     decoder_pc_out
);

   localparam int DEPTH   = 2 ** DEPTH_LOG2;
   localparam int COUNT_W = DEPTH_LOG2 + 1;

   logic [INSTRUCTION_WIDTH-1:0] memInst_q [DEPTH];
   logic [ADDRESS_WIDTH-1:0]     memPc_q   [DEPTH];

   logic [DEPTH_LOG2-1:0] head_q, head_d;
   logic [DEPTH_LOG2-1:0] tail_q, tail_d;
   logic [COUNT_W-1:0]    count_q, count_d;

   logic notEmpty;
   logic pop;
   logic push;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible while count covers them.
   always_ff @(posedge clk_in) begin
      if (push) begin
         memInst_q[tail_q] <= fetcher_inst_in;
         memPc_q[tail_q]   <= fetcher_pc_in;
      end
   end

   always_comb begin
      notEmpty = (count_q != '0);
      pop      = rdy_in & ~rob_flush_in & notEmpty & ~dispatcher_stall_in;
      push     = rdy_in & ~rob_flush_in & fetcher_en_in
                 & ((count_q != COUNT_W'(DEPTH)) | pop);

      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;

      if (rdy_in && rob_flush_in) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) tail_d = tail_q + 1'b1;
         if (pop)  head_d = head_q + 1'b1;
         count_d = count_q + COUNT_W'(push) - COUNT_W'(pop);
      end

      decoder_inst_en_out = pop;
      decoder_inst_out    = notEmpty ? memInst_q[head_q] : '0;
      decoder_pc_out      = notEmpty ? memPc_q[head_q]   : '0;
      fetcher_full_out    = (count_q >= COUNT_W'(DEPTH - FULL_SLACK));
   end

`ifndef SYNTHESIS
   // A push into a full queue without a pop means the fetcher ignored back-pressure.
   always_ff @(posedge clk_in) begin
      if (rst_n_in && rdy_in && !rob_flush_in && fetcher_en_in && !push)
         $warning("inst_queue: push dropped, queue full (pc=%h)", fetcher_pc_in);
   end
`endif

endmodule
